// File: rtl/btn_pkg.sv
// Shared constants and types for the button conditioner: button indices,
// default timing constants and the auto-repeat state encoding.
package btn_pkg;

    localparam int NUM_BTN   = 7;
    localparam int NUM_PULSE = 5;
    localparam int NUM_LEVEL = 2;

    localparam int BTN_UP        = 0;
    localparam int BTN_DOWN      = 1;
    localparam int BTN_SLIDE     = 2;
    localparam int BTN_OK        = 3;
    localparam int BTN_PW_ENDSET = 4;
    localparam int BTN_PLACE     = 5;
    localparam int BTN_PW_SET    = 6;

    // Cycle counts at a 25.2 MHz clock: 10 ms, 500 ms, 100 ms.
    localparam int DEF_DB_CYCLES     = 252000;
    localparam int DEF_REPEAT_DELAY  = 12600000;
    localparam int DEF_REPEAT_PERIOD = 2520000;

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_DELAY = 2'd1,
        R_RPT   = 2'd2
    } rpt_state_e;

    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/btn_conditioner_if.sv
// Button bundle between the board switches and the conditioner, plus the
// auto-repeat FSM states exported for debug visibility.
interface btn_conditioner_if;
    import btn_pkg::*;

    // No valid/ready here: btn_raw is free-running and asynchronous, btn_pulse
    // bits are single-cycle strobes and btn_level is a continuous level.
    logic [NUM_BTN-1:0]   btn_raw;
    logic [NUM_PULSE-1:0] btn_pulse;
    logic [NUM_LEVEL-1:0] btn_level;
    rpt_state_e           dbg_up_state;
    rpt_state_e           dbg_down_state;

    modport master (
        output btn_raw,
        input  btn_pulse,
        input  btn_level,
        input  dbg_up_state,
        input  dbg_down_state
    );

    modport slave (
        input  btn_raw,
        output btn_pulse,
        output btn_level,
        output dbg_up_state,
        output dbg_down_state
    );

endinterface

// File: rtl/btn_debounce.sv
// One-bit debouncer: 2-flop synchronizer, saturating stability counter and
// the accepted (stable) level.
module btn_debounce #(
    parameter int DB_CYCLES = btn_pkg::DEF_DB_CYCLES,
    parameter int CW        = 18
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_i,
    output logic stable_o
);

    logic          meta_q;
    logic          sync_q;
    logic          stable_q;
    logic          stable_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // The counter only runs while the synchronized input disagrees with the
    // accepted level; any agreement restarts the stability window.
    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        if (sync_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q >= CW'(DB_CYCLES - 1)) begin
            stable_d = ~stable_q;
            cnt_d    = '0;
        end else if (cnt_q != '1) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q   <= 1'b0;
            sync_q   <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            meta_q   <= raw_i;
            sync_q   <= meta_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable_o = stable_q;

endmodule

// File: rtl/btn_conditioner.sv
// Debounces seven board buttons, turns five into press strobes and passes two
// through as levels. Optional up/down auto-repeat under macro BTN_AUTOREPEAT_EN.
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int DB_CYCLES     = DEF_DB_CYCLES,
    parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
    input  logic             clk,
    input  logic             rst,
    btn_conditioner_if.slave bus
);

    localparam int CW = cnt_width(DB_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);

    logic [NUM_BTN-1:0]   stable;
    logic [NUM_PULSE-1:0] stable_prev_q;
    logic [NUM_PULSE-1:0] rise;
    logic                 both_ud;
    logic [NUM_PULSE-1:2] hi_pulse_q;
    logic [1:0]           ud_pulse_q;
    logic [NUM_LEVEL-1:0] level_q;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_db
        btn_debounce #(
            .DB_CYCLES (DB_CYCLES),
            .CW        (CW)
        ) u_db (
            .clk      (clk),
            .rst      (rst),
            .raw_i    (bus.btn_raw[i]),
            .stable_o (stable[i])
        );
    end

    assign rise    = stable[NUM_PULSE-1:0] & ~stable_prev_q;
    assign both_ud = stable[BTN_UP] & stable[BTN_DOWN];

    // Levels are registered alongside the strobes so both share one latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            stable_prev_q <= '0;
            hi_pulse_q    <= '0;
            level_q       <= '0;
        end else begin
            stable_prev_q <= stable[NUM_PULSE-1:0];
            hi_pulse_q    <= rise[NUM_PULSE-1:2];
            level_q       <= stable[BTN_PW_SET:BTN_PLACE];
        end
    end

`ifdef BTN_AUTOREPEAT_EN
    rpt_state_e    state_q [2];
    logic [CW-1:0] rcnt_q  [2];

    // Up and down share one block; a simultaneous hold of both cancels either.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                state_q[i]    <= R_IDLE;
                rcnt_q[i]     <= '0;
                ud_pulse_q[i] <= 1'b0;
            end else begin
                ud_pulse_q[i] <= 1'b0;
                if (both_ud || !stable[i]) begin
                    state_q[i] <= R_IDLE;
                    rcnt_q[i]  <= '0;
                end else begin
                    case (state_q[i])
                        R_IDLE: begin
                            if (rise[i]) begin
                                ud_pulse_q[i] <= 1'b1;
                                state_q[i]    <= R_DELAY;
                                rcnt_q[i]     <= '0;
                            end
                        end
                        R_DELAY: begin
                            if (rcnt_q[i] >= CW'(REPEAT_DELAY - 1)) begin
                                ud_pulse_q[i] <= 1'b1;
                                state_q[i]    <= R_RPT;
                                rcnt_q[i]     <= '0;
                            end else if (rcnt_q[i] != '1) begin
                                rcnt_q[i] <= rcnt_q[i] + CW'(1);
                            end
                        end
                        R_RPT: begin
                            if (rcnt_q[i] >= CW'(REPEAT_PERIOD - 1)) begin
                                ud_pulse_q[i] <= 1'b1;
                                rcnt_q[i]     <= '0;
                            end else if (rcnt_q[i] != '1) begin
                                rcnt_q[i] <= rcnt_q[i] + CW'(1);
                            end
                        end
                        default: begin
                            state_q[i] <= R_IDLE;
                            rcnt_q[i]  <= '0;
                        end
                    endcase
                end
            end
        end
    end

    assign bus.dbg_up_state   = state_q[0];
    assign bus.dbg_down_state = state_q[1];
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            ud_pulse_q <= '0;
        end else begin
            ud_pulse_q <= both_ud ? 2'b00 : rise[1:0];
        end
    end

    assign bus.dbg_up_state   = R_IDLE;
    assign bus.dbg_down_state = R_IDLE;
`endif

    assign bus.btn_pulse = {hi_pulse_q, ud_pulse_q};
    assign bus.btn_level = level_q;

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner: directed scenarios with literal expectations plus
// randomized holds/glitches checked every cycle against a behavioural model.
module tb_btn_conditioner;
    import btn_pkg::*;

    localparam int DB = 4;
    localparam int RD = 20;
    localparam int RP = 8;

    typedef int int_q_t[$];

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cycle = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    btn_conditioner_if bus();

    btn_conditioner #(
        .DB_CYCLES     (DB),
        .REPEAT_DELAY  (RD),
        .REPEAT_PERIOD (RP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cycle++;

    // ---------------- check helpers ----------------
    function automatic void check_vec(input string name, input logic [6:0] act, input logic [6:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %b, expected %b", name, cycle, act, exp);
        end
    endfunction

    function automatic void check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %0d, expected %0d", name, cycle, act, exp);
        end
    endfunction

    // ---------------- behavioural model ----------------
    // Accepted level flips after DB consecutive samples disagree with it; the
    // samples reach the filter two clocks after the raw pin. Outputs lag the
    // accepted level by one clock. Up/down repeat is derived from hold age.
    logic [6:0] exp_q[$];
    logic [6:0] raw_hist[$];
    logic [6:0] acc;
    logic [6:0] acc_prev;
    int         run [7];
    bit         armed [2];
    int         age [2];

    always @(posedge clk) begin
        logic [6:0] smp;
        logic [4:0] p;
        logic       both;
        if (rst) begin
            raw_hist = '{7'd0, 7'd0};
            acc      = '0;
            acc_prev = '0;
            for (int b = 0; b < 7; b++) run[b] = 0;
            for (int i = 0; i < 2; i++) begin
                armed[i] = 1'b0;
                age[i]   = 0;
            end
            exp_q.push_back(7'd0);
        end else begin
            raw_hist.push_back(bus.btn_raw);
            smp  = raw_hist.pop_front();
            p    = acc[4:0] & ~acc_prev[4:0];
            both = acc[0] & acc[1];
            for (int i = 0; i < 2; i++) begin
                if (both) begin
                    p[i]     = 1'b0;
                    armed[i] = 1'b0;
                end else if (p[i]) begin
                    armed[i] = 1'b1;
                    age[i]   = 0;
                end else if (armed[i] && acc[i]) begin
                    age[i]++;
`ifdef BTN_AUTOREPEAT_EN
                    p[i] = (age[i] >= RD) && (((age[i] - RD) % RP) == 0);
`endif
                end else begin
                    armed[i] = 1'b0;
                end
            end
            exp_q.push_back({acc[6:5], p});
            acc_prev = acc;
            for (int b = 0; b < 7; b++) begin
                if (smp[b] != acc[b]) begin
                    run[b]++;
                    if (run[b] == DB) begin
                        acc[b] = smp[b];
                        run[b] = 0;
                    end
                end else begin
                    run[b] = 0;
                end
            end
        end
    end

    // ---------------- scoreboard / event log ----------------
    int         ev_cyc[$];
    logic [4:0] ev_val[$];
    int         lv_cyc[$];
    logic [1:0] lv_val[$];
    logic [1:0] lvl_prev = 2'b00;

    always @(negedge clk) begin
        logic [6:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_vec("model", {bus.btn_level, bus.btn_pulse}, e);
        end
        if (bus.btn_pulse != 5'd0) begin
            ev_cyc.push_back(cycle);
            ev_val.push_back(bus.btn_pulse);
        end
        if (bus.btn_level !== lvl_prev) begin
            lv_cyc.push_back(cycle);
            lv_val.push_back(bus.btn_level);
            lvl_prev = bus.btn_level;
        end
    end

    function automatic int_q_t pulse_offsets(input int t0, input logic [4:0] mask);
        int_q_t q;
        foreach (ev_cyc[k])
            if (ev_cyc[k] > t0 && (ev_val[k] & mask) != 5'd0) q.push_back(ev_cyc[k] - t0);
        return q;
    endfunction

    function automatic int level_offset(input int t0, input logic [1:0] want);
        foreach (lv_cyc[k])
            if (lv_cyc[k] > t0 && lv_val[k] == want) return lv_cyc[k] - t0;
        return -1;
    endfunction

    // ---------------- driver ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int     t0;
        int     tr;
        int_q_t q;
        int_q_t exp_off;

        bus.btn_raw = 7'd0;
        rst = 1'b1;
        step(4);
        check_vec("reset_outputs", {bus.btn_level, bus.btn_pulse}, 7'd0);
        check_int("reset_dbg_up", int'(bus.dbg_up_state), int'(R_IDLE));
        check_int("reset_dbg_down", int'(bus.dbg_down_state), int'(R_IDLE));
        rst = 1'b0;
        step(10);
        check_vec("post_reset_outputs", {bus.btn_level, bus.btn_pulse}, 7'd0);

        // Short hold of up: one strobe at DB+3, nothing on release.
        t0 = cycle;
        bus.btn_raw = 7'b0000001;
        step(10);
        bus.btn_raw = 7'd0;
        step(20);
        q = pulse_offsets(t0, 5'b11111);
        check_int("hold10_total_pulses", q.size(), 1);
        q = pulse_offsets(t0, 5'b00001);
        check_int("hold10_up_pulses", q.size(), 1);
        check_int("hold10_offset", (q.size() > 0) ? q[0] : -1, 7);

        // 3-cycle glitch on OK.
        t0 = cycle;
        bus.btn_raw = 7'b0001000;
        step(3);
        bus.btn_raw = 7'd0;
        step(15);
        q = pulse_offsets(t0, 5'b11111);
        check_int("glitch_pulses", q.size(), 0);

        // Level button place.
        t0 = cycle;
        bus.btn_raw = 7'b0100000;
        step(12);
        check_int("place_rise_offset", level_offset(t0, 2'b01), 7);
        tr = cycle;
        bus.btn_raw = 7'd0;
        step(12);
        check_int("place_fall_offset", level_offset(tr, 2'b00), 7);
        q = pulse_offsets(t0, 5'b11111);
        check_int("place_pulses", q.size(), 0);

        // Long hold of up.
        t0 = cycle;
        bus.btn_raw = 7'b0000001;
        step(60);
        bus.btn_raw = 7'd0;
        step(20);
`ifdef BTN_AUTOREPEAT_EN
        exp_off = '{7, 27, 35, 43, 51, 59};
`else
        exp_off = '{7};
`endif
        q = pulse_offsets(t0, 5'b11111);
        check_int("hold60_count", q.size(), exp_off.size());
        foreach (exp_off[k])
            check_int($sformatf("hold60_offset%0d", k), (k < q.size()) ? q[k] : -1, exp_off[k]);

        // Up held, then down added: both held cancels up/down strobes.
        t0 = cycle;
        bus.btn_raw = 7'b0000001;
        step(15);
        q = pulse_offsets(t0, 5'b00001);
        check_int("ud_up_first", q.size(), 1);
        t0 = cycle;
        bus.btn_raw = 7'b0000011;
        step(30);
        q = pulse_offsets(t0, 5'b00011);
        check_int("ud_both_pulses", q.size(), 0);
        t0 = cycle;
        bus.btn_raw = 7'b0000001;
        step(40);
        q = pulse_offsets(t0, 5'b11111);
        check_int("ud_down_release_pulses", q.size(), 0);
        t0 = cycle;
        bus.btn_raw = 7'd0;
        step(20);
        q = pulse_offsets(t0, 5'b11111);
        check_int("ud_up_release_pulses", q.size(), 0);
        t0 = cycle;
        bus.btn_raw = 7'b0000010;
        step(12);
        bus.btn_raw = 7'd0;
        step(15);
        q = pulse_offsets(t0, 5'b00010);
        check_int("ud_down_repress_count", q.size(), 1);
        check_int("ud_down_repress_offset", (q.size() > 0) ? q[0] : -1, 7);
        q = pulse_offsets(t0, 5'b00001);
        check_int("ud_down_repress_no_up", q.size(), 0);

        // Reset at cycle 3 of a debounce, button held through deassert.
        t0 = cycle;
        bus.btn_raw = 7'b0000001;
        step(3);
        rst = 1'b1;
        step(3);
        rst = 1'b0;
        tr = cycle;
        step(14);
        bus.btn_raw = 7'd0;
        step(15);
        q = pulse_offsets(t0, 5'b11111);
        check_int("rst_mid_count", q.size(), 1);
        check_int("rst_mid_offset", (q.size() > 0) ? q[0] + t0 - tr : -1, 7);

        // Randomized holds, glitches and occasional resets.
        for (int s = 0; s < 120; s++) begin
            bus.btn_raw = 7'($urandom_range(0, 127));
            if ($urandom_range(0, 2) == 0) step($urandom_range(1, 5));
            else step($urandom_range(8, 70));
            if ($urandom_range(0, 29) == 0) begin
                rst = 1'b1;
                step($urandom_range(1, 3));
                rst = 1'b0;
            end
        end
        bus.btn_raw = 7'd0;
        step(20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/btn_conditioner.md
BTN_CONDITIONER -- requirements
Module: btn_conditioner

Interface
REQ-001 Parameter DB_CYCLES, default 252000 (10 ms at 25.2 MHz): number of consecutive stable cycles required to accept a new debounced level.
REQ-002 Parameter REPEAT_DELAY, default 12600000 (500 ms): hold time before auto-repeat begins.
REQ-003 Parameter REPEAT_PERIOD, default 2520000 (100 ms): interval between auto-repeat pulses.
REQ-004 Port clk, input, 1 bit: 25.2 MHz system clock; all logic on its rising edge.
REQ-005 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 Port btn_raw, input, 7 bits: asynchronous raw switches, indexed [0]up [1]down [2]slide [3]OK [4]PW_endset [5]place [6]PW_set.
REQ-007 Port btn_pulse, output, 5 bits: one-cycle press strobes for up, down, slide, OK and PW_endset, in that index order.
REQ-008 Port btn_level, output, 2 bits: debounced levels, [0]place and [1]PW_set.

Function
REQ-009 Each btn_raw bit SHALL pass through a 2-flop synchronizer before any other use.
REQ-010 Each bit SHALL have a stable register and a counter; the counter clears whenever the synchronized input equals the stable value.
REQ-011 While the synchronized input differs from the stable value, the counter SHALL increment; on reaching DB_CYCLES-1 the stable value SHALL toggle and the counter SHALL clear.
REQ-012 A glitch shorter than DB_CYCLES cycles SHALL produce no change in the stable value.
REQ-013 btn_pulse[i] SHALL be high for exactly one cycle, in the cycle after the stable value of bits 0-4 rises; a release SHALL produce no pulse.
REQ-014 Latency from a btn_raw edge to btn_pulse or btn_level SHALL be DB_CYCLES+3 cycles for an input held stable throughout.
REQ-015 btn_level SHALL equal the stable values of bits 5-6 directly, with no pulse generation.
REQ-016 When up and down are both stably high, btn_pulse[1:0] SHALL be 0 and the repeat state SHALL return to R_IDLE.
REQ-017 Pressing either up or down alone afterwards SHALL behave as a fresh press.
REQ-018 Counters SHALL saturate and never wrap; the counter width is clog2 of the largest parameter.

Reset
REQ-019 rst SHALL clear all synchronizers, stable registers, counters and repeat FSMs.
REQ-020 btn_pulse SHALL be 0 and btn_level SHALL be 0 during and after reset.
REQ-021 A button already held when rst deasserts SHALL be accepted after DB_CYCLES+3 cycles and SHALL produce one pulse.
REQ-022 Reset asserted mid-debounce or mid-repeat SHALL discard the pending event.

Configuration
REQ-023 With macro BTN_AUTOREPEAT_EN defined, up and down SHALL each run an FSM: R_IDLE goes to R_DELAY on the initial pulse.
REQ-024 After REPEAT_DELAY cycles still pressed, R_DELAY SHALL pulse once and move to R_RPT.
REQ-025 R_RPT SHALL pulse every REPEAT_PERIOD cycles while pressed.
REQ-026 A stable release SHALL return the FSM to R_IDLE from any state, with no pulse.
REQ-027 Without BTN_AUTOREPEAT_EN, no repeat logic SHALL be synthesized, and a hold SHALL yield exactly one pulse.

Structure
REQ-028 Package btn_pkg SHALL hold the button index constants, the default cycle constants and the repeat-state enumeration (R_IDLE, R_DELAY, R_RPT).
REQ-029 Sub-module btn_debounce (synchronizer, counter and stable register for one bit) SHALL be instantiated 7 times.
REQ-030 Edge detection and auto-repeat logic SHALL stay in the top module.

Verification (DB_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8)
REQ-031 Hold btn_raw[0]=1 for 10 cycles: btn_pulse=5'b00001 for exactly one cycle, 7 cycles after the edge (DB_CYCLES+3); no pulse on release.
REQ-032 Apply a 3-cycle glitch on btn_raw[3]: btn_pulse stays 0.
REQ-033 Set btn_raw[5]=1: btn_level[0]=1 after 7 cycles; clear it: btn_level[0]=0 after 7 cycles; btn_pulse stays 0 throughout.
REQ-034 With BTN_AUTOREPEAT_EN, hold up for 60 cycles: pulses at offsets 7, 27, 35, 43, 51 and 59.
REQ-035 Without BTN_AUTOREPEAT_EN, the same hold gives a single pulse.
REQ-036 Press up, then press down while up is held: no pulses once both are stable; release down: no pulse from up; re-press down: one down pulse.
REQ-037 Assert rst at cycle 3 of a debounce: no pulse; hold the button through rst deassert: one pulse 7 cycles after deassert.
